// File: rtl/crs_pkg.sv
// Shared definitions for the UART-to-crs_master command bridge: command codes,
// response byte defaults and the frame-parser state encoding.
package crs_pkg;

    localparam logic [7:0] CMD_WR       = 8'h01;
    localparam logic [7:0] CMD_RD       = 8'h02;
    localparam logic [7:0] ACK_BYTE_DEF = 8'hA5;
    localparam logic [7:0] ERR_BYTE_DEF = 8'hEE;

    typedef enum logic [3:0] {
        S_CMD,
        S_ADR_H,
        S_ADR_L,
        S_DAT_H,
        S_DAT_L,
        S_REQ,
        S_ACK_WAIT,
        S_TX_H,
        S_TX_L
    } state_e;

endpackage

// File: rtl/crs_uart_bridge.sv
// Parses UART command frames into single-word crs_master reads/writes and returns
// ACK or read data. Optional inter-byte timeout: define CRS_UART_TIMEOUT_EN.
module crs_uart_bridge
    import crs_pkg::*;
#(
    parameter logic [7:0] ACK_BYTE       = ACK_BYTE_DEF,
    parameter logic [7:0] ERR_BYTE       = ERR_BYTE_DEF,
    parameter int         TIMEOUT_CYCLES = 20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        crs_wr_req,
    output logic        crs_rd_req,
    output logic        crs_bwr_req,
    output logic [11:0] crs_adr,
    output logic [15:0] crs_wr_data,
    input  logic [15:0] crs_rd_data,
    input  logic        crs_ack,
    output logic [7:0]  err_cnt
);

    state_e      state_q, state_d;
    logic        is_rd_q, is_rd_d;
    logic [11:0] adr_q, adr_d;
    logic [15:0] wdat_q, wdat_d;
    logic [15:0] rdat_q, rdat_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  err_q, err_d;
    logic        err_evt;
    logic        in_parse;

    assign in_parse = (state_q == S_ADR_H) || (state_q == S_ADR_L) ||
                      (state_q == S_DAT_H) || (state_q == S_DAT_L);

`ifdef CRS_UART_TIMEOUT_EN
    localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
    logic [GW-1:0] gap_q, gap_d;
    logic          timeout;

    // Gap counter runs only mid-frame; any received byte restarts it.
    assign timeout = in_parse && !rx_valid && (gap_q == GW'(TIMEOUT_CYCLES - 1));
    assign gap_d   = (!in_parse || rx_valid || timeout) ? '0 : gap_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) gap_q <= '0;
        else     gap_q <= gap_d;
    end
`else
    logic timeout;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        is_rd_d = is_rd_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        tx_d    = tx_q;
        err_evt = 1'b0;
        case (state_q)
            S_CMD: if (rx_valid) begin
                if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                    is_rd_d = (rx_data == CMD_RD);
                    state_d = S_ADR_H;
                end else begin
                    tx_d    = ERR_BYTE;
                    err_evt = 1'b1;
                    state_d = S_TX_L;
                end
            end
            S_ADR_H: if (rx_valid) begin
                adr_d[11:8] = rx_data[3:0];
                state_d     = S_ADR_L;
            end
            S_ADR_L: if (rx_valid) begin
                adr_d[7:0] = rx_data;
                state_d    = is_rd_q ? S_REQ : S_DAT_H;
            end
            S_DAT_H: if (rx_valid) begin
                wdat_d[15:8] = rx_data;
                state_d      = S_DAT_L;
            end
            S_DAT_L: if (rx_valid) begin
                wdat_d[7:0] = rx_data;
                state_d     = S_REQ;
            end
            S_REQ: if (crs_ack) begin
                rdat_d  = crs_rd_data;
                state_d = S_ACK_WAIT;
            end
            // Wait for ack to drop so the next request can never overlap it.
            S_ACK_WAIT: if (!crs_ack) begin
                tx_d    = is_rd_q ? rdat_q[15:8] : ACK_BYTE;
                state_d = is_rd_q ? S_TX_H : S_TX_L;
            end
            S_TX_H: if (tx_ready) begin
                tx_d    = rdat_q[7:0];
                state_d = S_TX_L;
            end
            S_TX_L: if (tx_ready) state_d = S_CMD;
            default: state_d = S_CMD;
        endcase
        // Bytes arriving while a command is in flight are overruns.
        if (rx_valid && !in_parse && state_q != S_CMD) err_evt = 1'b1;
        if (timeout) begin
            err_evt = 1'b1;
            state_d = S_CMD;
        end
        err_d = (err_evt && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CMD;
            is_rd_q <= 1'b0;
            adr_q   <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            tx_q    <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            is_rd_q <= is_rd_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            tx_q    <= tx_d;
            err_q   <= err_d;
        end
    end

    // Requests decode straight from the state register so reset drops them at once.
    assign crs_wr_req  = (state_q == S_REQ) && !is_rd_q;
    assign crs_rd_req  = (state_q == S_REQ) && is_rd_q;
    assign crs_bwr_req = 1'b0;
    assign crs_adr     = adr_q;
    assign crs_wr_data = wdat_q;
    assign tx_valid    = (state_q == S_TX_H) || (state_q == S_TX_L);
    assign tx_data     = tx_q;
    assign err_cnt     = err_q;

endmodule

// File: tb/tb_crs_uart_bridge.sv
// Directed bench for crs_uart_bridge: per-cycle vector table plus hand sequences
// for backpressure, saturation, reset mid-request and the optional timeout.
module tb_crs_uart_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        crs_wr_req, crs_rd_req, crs_bwr_req;
    logic [11:0] crs_adr;
    logic [15:0] crs_wr_data;
    logic [15:0] crs_rd_data = '0;
    logic        crs_ack = 1'b0;
    logic [7:0]  err_cnt;

    localparam int TO = 20000;

    int n_chk = 0;
    int n_fail = 0;

    crs_uart_bridge dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .crs_wr_req(crs_wr_req), .crs_rd_req(crs_rd_req), .crs_bwr_req(crs_bwr_req),
        .crs_adr(crs_adr), .crs_wr_data(crs_wr_data), .crs_rd_data(crs_rd_data),
        .crs_ack(crs_ack), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rxv;
        logic [7:0]  rxd;
        logic        ack;
        logic [15:0] rdd;
        logic        txr;
        logic        wr;
        logic        rd;
        logic [11:0] adr;
        logic [15:0] wdat;
        logic        txv;
        logic [7:0]  txd;
        logic [7:0]  err;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic r, input logic rv, input logic [7:0] rd_,
                       input logic a, input logic [15:0] d, input logic tr,
                       input logic ew, input logic er, input logic [11:0] ea,
                       input logic [15:0] ewd, input logic etv, input logic [7:0] etd,
                       input logic [7:0] ee);
        vec_t v;
        v.rst = r; v.rxv = rv; v.rxd = rd_; v.ack = a; v.rdd = d; v.txr = tr;
        v.wr = ew; v.rd = er; v.adr = ea; v.wdat = ewd; v.txv = etv; v.txd = etd; v.err = ee;
        vt.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    // Drive one cycle of inputs at negedge, let the posedge consume them, settle.
    task automatic cyc(input logic r, input logic rv, input logic [7:0] rd_,
                       input logic a, input logic [15:0] d, input logic tr);
        @(negedge clk);
        rst = r; rx_valid = rv; rx_data = rd_; crs_ack = a; crs_rd_data = d; tx_ready = tr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 8'h00, 0, 16'h0, 0);
    endtask

    initial begin
        //    rst rv rxd    ack rdd       txr | wr rd adr     wdat      txv txd    err
        add(1, 0, 8'h00, 0, 16'h0000, 0,  0, 0, 12'h000, 16'h0000, 0, 8'h00, 8'd0);
        // write 01 0F 23 BE EF, ack after 3 cycles
        add(0, 1, 8'h01, 0, 16'h0000, 0,  0, 0, 12'h000, 16'h0000, 0, 8'h00, 8'd0);
        add(0, 1, 8'h0F, 0, 16'h0000, 0,  0, 0, 12'hF00, 16'h0000, 0, 8'h00, 8'd0);
        add(0, 1, 8'h23, 0, 16'h0000, 0,  0, 0, 12'hF23, 16'h0000, 0, 8'h00, 8'd0);
        add(0, 1, 8'hBE, 0, 16'h0000, 0,  0, 0, 12'hF23, 16'hBE00, 0, 8'h00, 8'd0);
        add(0, 1, 8'hEF, 0, 16'h0000, 0,  1, 0, 12'hF23, 16'hBEEF, 0, 8'h00, 8'd0);
        add(0, 0, 8'h00, 0, 16'h0000, 0,  1, 0, 12'hF23, 16'hBEEF, 0, 8'h00, 8'd0);
        add(0, 0, 8'h00, 0, 16'h0000, 0,  1, 0, 12'hF23, 16'hBEEF, 0, 8'h00, 8'd0);
        add(0, 0, 8'h00, 1, 16'h0000, 0,  0, 0, 12'hF23, 16'hBEEF, 0, 8'h00, 8'd0);
        add(0, 0, 8'h00, 0, 16'h0000, 0,  0, 0, 12'hF23, 16'hBEEF, 1, 8'hA5, 8'd0);
        add(0, 0, 8'h00, 0, 16'h0000, 1,  0, 0, 12'hF23, 16'hBEEF, 0, 8'hA5, 8'd0);
        // read 02 A1 05, ack held two cycles with 0x1234
        add(0, 1, 8'h02, 0, 16'h0000, 0,  0, 0, 12'hF23, 16'hBEEF, 0, 8'hA5, 8'd0);
        add(0, 1, 8'hA1, 0, 16'h0000, 0,  0, 0, 12'h123, 16'hBEEF, 0, 8'hA5, 8'd0);
        add(0, 1, 8'h05, 0, 16'h0000, 0,  0, 1, 12'h105, 16'hBEEF, 0, 8'hA5, 8'd0);
        add(0, 0, 8'h00, 1, 16'h1234, 0,  0, 0, 12'h105, 16'hBEEF, 0, 8'hA5, 8'd0);
        add(0, 0, 8'h00, 1, 16'h1234, 0,  0, 0, 12'h105, 16'hBEEF, 0, 8'hA5, 8'd0);
        add(0, 0, 8'h00, 0, 16'h0000, 0,  0, 0, 12'h105, 16'hBEEF, 1, 8'h12, 8'd0);
        add(0, 0, 8'h00, 0, 16'h0000, 1,  0, 0, 12'h105, 16'hBEEF, 1, 8'h34, 8'd0);
        add(0, 0, 8'h00, 0, 16'h0000, 1,  0, 0, 12'h105, 16'hBEEF, 0, 8'h34, 8'd0);
        // bad command, then a read with an overrun byte during the request
        add(0, 1, 8'h7E, 0, 16'h0000, 0,  0, 0, 12'h105, 16'hBEEF, 1, 8'hEE, 8'd1);
        add(0, 0, 8'h00, 0, 16'h0000, 1,  0, 0, 12'h105, 16'hBEEF, 0, 8'hEE, 8'd1);
        add(0, 1, 8'h02, 0, 16'h0000, 0,  0, 0, 12'h105, 16'hBEEF, 0, 8'hEE, 8'd1);
        add(0, 1, 8'h00, 0, 16'h0000, 0,  0, 0, 12'h005, 16'hBEEF, 0, 8'hEE, 8'd1);
        add(0, 1, 8'h10, 0, 16'h0000, 0,  0, 1, 12'h010, 16'hBEEF, 0, 8'hEE, 8'd1);
        add(0, 1, 8'hAA, 0, 16'h0000, 0,  0, 1, 12'h010, 16'hBEEF, 0, 8'hEE, 8'd2);
        add(0, 0, 8'h00, 1, 16'h5678, 0,  0, 0, 12'h010, 16'hBEEF, 0, 8'hEE, 8'd2);
        add(0, 0, 8'h00, 0, 16'h0000, 0,  0, 0, 12'h010, 16'hBEEF, 1, 8'h56, 8'd2);
        add(0, 0, 8'h00, 0, 16'h0000, 1,  0, 0, 12'h010, 16'hBEEF, 1, 8'h78, 8'd2);
        add(0, 0, 8'h00, 0, 16'h0000, 1,  0, 0, 12'h010, 16'hBEEF, 0, 8'h78, 8'd2);

        for (int i = 0; i < vt.size(); i++) begin
            cyc(vt[i].rst, vt[i].rxv, vt[i].rxd, vt[i].ack, vt[i].rdd, vt[i].txr);
            chk($sformatf("v%0d wr_req", i), 32'(crs_wr_req), 32'(vt[i].wr));
            chk($sformatf("v%0d rd_req", i), 32'(crs_rd_req), 32'(vt[i].rd));
            chk($sformatf("v%0d bwr_req", i), 32'(crs_bwr_req), 32'd0);
            chk($sformatf("v%0d adr", i), 32'(crs_adr), 32'(vt[i].adr));
            chk($sformatf("v%0d wr_data", i), 32'(crs_wr_data), 32'(vt[i].wdat));
            chk($sformatf("v%0d tx_valid", i), 32'(tx_valid), 32'(vt[i].txv));
            chk($sformatf("v%0d tx_data", i), 32'(tx_data), 32'(vt[i].txd));
            chk($sformatf("v%0d err_cnt", i), 32'(err_cnt), 32'(vt[i].err));
        end

        // Backpressure: read 02 03 04 returning 0x1234, tx_ready low for 50 cycles
        cyc(0, 1, 8'h02, 0, 16'h0, 0);
        cyc(0, 1, 8'h03, 0, 16'h0, 0);
        cyc(0, 1, 8'h04, 0, 16'h0, 0);
        chk("bp rd_req", 32'({crs_rd_req, crs_adr}), 32'({1'b1, 12'h304}));
        cyc(0, 0, 8'h00, 1, 16'h1234, 0);
        cyc(0, 0, 8'h00, 0, 16'h0, 0);
        for (int i = 0; i < 50; i++) begin
            chk($sformatf("bp hold %0d", i), 32'({tx_valid, tx_data}), 32'({1'b1, 8'h12}));
            cyc(0, 0, 8'h00, 0, 16'h0, 0);
        end
        cyc(0, 0, 8'h00, 0, 16'h0, 1);
        chk("bp second byte", 32'({tx_valid, tx_data}), 32'({1'b1, 8'h34}));
        cyc(0, 0, 8'h00, 0, 16'h0, 1);
        chk("bp done", 32'(tx_valid), 32'd0);

        // Saturation: every cycle carries an error event (bad cmd or overrun)
        cyc(1, 0, 8'h00, 0, 16'h0, 0);
        chk("sat reset err", 32'(err_cnt), 32'd0);
        for (int i = 0; i < 300; i++) begin
            cyc(0, 1, 8'h7E, 0, 16'h0, 1);
            if (i == 9) chk("sat err@10", 32'(err_cnt), 32'd10);
        end
        chk("sat err=255", 32'(err_cnt), 32'd255);

        // Reset in the middle of a write request
        cyc(0, 0, 8'h00, 0, 16'h0, 1);
        cyc(0, 1, 8'h01, 0, 16'h0, 0);
        cyc(0, 1, 8'h01, 0, 16'h0, 0);
        cyc(0, 1, 8'h02, 0, 16'h0, 0);
        cyc(0, 1, 8'h33, 0, 16'h0, 0);
        cyc(0, 1, 8'h44, 0, 16'h0, 0);
        chk("rst pre wr_req", 32'({crs_wr_req, crs_adr, crs_wr_data}), 32'({1'b1, 12'h102, 16'h3344}));
        cyc(1, 0, 8'h00, 0, 16'h0, 0);
        chk("rst outputs", 32'({crs_wr_req, crs_rd_req, tx_valid, tx_data, err_cnt}), 32'd0);
        chk("rst adr/wdat", 32'({crs_adr, crs_wr_data}), 32'd0);

`ifdef CRS_UART_TIMEOUT_EN
        cyc(0, 1, 8'h01, 0, 16'h0, 0);
        cyc(0, 1, 8'h0F, 0, 16'h0, 0);
        idle(TO - 1);
        chk("to before", 32'(err_cnt), 32'd0);
        idle(1);
        chk("to err", 32'(err_cnt), 32'd1);
        chk("to no tx", 32'(tx_valid), 32'd0);
        cyc(0, 1, 8'h01, 0, 16'h0, 0);
        cyc(0, 1, 8'h0A, 0, 16'h0, 0);
        cyc(0, 1, 8'hBC, 0, 16'h0, 0);
        cyc(0, 1, 8'h12, 0, 16'h0, 0);
        cyc(0, 1, 8'h34, 0, 16'h0, 0);
        chk("to next frame", 32'({crs_wr_req, crs_adr, crs_wr_data}), 32'({1'b1, 12'hABC, 16'h1234}));
`else
        idle(2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
